ctrl_link_tx: RTL and testbench
===============================

CTRL_LINK_TX -- requirements
Module: ctrl_link_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; BIT_TICKS = CLK_HZ/BAUD (integer division, 868 at defaults).
REQ-003 Parameter GAP_BITS, default 4, idle-high bit times inserted between consecutive frames (range 1..15).
REQ-004 clk  input  1  system clock; one clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  high = transmit frames continuously; low = finish current frame, then hold idle.
REQ-007 btn  input  5  live button vector {attack, right, left, down, up}; bit 0 = up.
REQ-008 tx_line  output  1  serial line to the partner board's pmod pin; idles high.
REQ-009 busy  output  1  high from the first clock of the start bit through the last clock of the stop bit.
REQ-010 frame_done  output  1  single-clock pulse on the last clock of each stop bit.

Function
REQ-011 Frame SHALL be 8 bit times: start (0), btn[0]..btn[4] LSB first, even parity over btn (XOR of the 5 bits), stop (1).
REQ-012 Each bit SHALL hold tx_line stable for exactly BIT_TICKS clocks, timed by a modulo-BIT_TICKS counter that restarts at 0 on every bit boundary.
REQ-013 btn SHALL be latched into a shadow register on the clock the FSM leaves IDLE; changes on btn during a frame SHALL NOT alter that frame.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
REQ-015 IDLE -> START when enable is high; tx_line drives 0 from the next clock.
REQ-016 START -> DATA after BIT_TICKS clocks; DATA -> PARITY after 5 bit times (3-bit bit index 0..4, then cleared); PARITY -> STOP after 1 bit time.
REQ-017 STOP -> GAP after 1 bit time; GAP -> START after GAP_BITS bit times if enable is high, otherwise GAP -> IDLE.
REQ-018 Deasserting enable mid-frame SHALL NOT truncate the frame; the line returns to idle only after STOP and GAP complete.
REQ-019 Frame period at sustained enable SHALL be exactly (8 + GAP_BITS) x BIT_TICKS clocks (10,416 at defaults).
REQ-020 tx_line SHALL be a registered output (no combinational path from btn or enable).
REQ-021 busy SHALL be low in IDLE and GAP, high in START, DATA, PARITY, STOP.

Reset
REQ-022 On reset assertion, immediately and regardless of clock: state = IDLE, tx_line = 1, busy = 0, frame_done = 0, tick counter = 0, bit index = 0, shadow register = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no further line transitions; after release the first frame starts with a fresh START bit.
REQ-024 After reset release, the first START SHALL begin no earlier than the clock after enable is sampled high.

Structure
REQ-025 Shared package ctrl_link_pkg SHALL hold the FSM state encoding, FRAME_DATA_BITS = 5, FRAME_BITS = 8, and the btn bit-position constants (UP=0, DOWN=1, LEFT=2, RIGHT=3, ATTACK=4), so that the matching receiver uses identical definitions.
REQ-026 One sub-module, baud_tick_gen (parameter BIT_TICKS; inputs clk, reset, restart; output tick), SHALL provide the bit-boundary strobe.

Verification
REQ-027 Defaults, enable=1, btn=5'b00101 -> tx_line bit sequence 0,1,0,1,0,0,0,1, each bit 868 clocks wide; frame_done pulses once at clock 6,944 after START begins.
REQ-028 btn=5'b10110 held, enable=1 for 3 frames -> each frame carries data 0,1,1,0,1 and parity 1; START edges are spaced exactly 10,416 clocks apart.
REQ-029 btn changes from 5'b00001 to 5'b11111 during DATA bit 2 -> current frame still carries 1,0,0,0,0 with parity 1; next frame carries 1,1,1,1,1 with parity 1.
REQ-030 enable dropped during PARITY -> STOP and 4 GAP bit times complete, then tx_line stays 1 and busy stays 0 indefinitely.
REQ-031 reset pulsed for 3 clocks during DATA bit 3 -> tx_line = 1 and busy = 0 within the same clock as assertion; after release with enable=1 a full new frame starts cleanly.
REQ-032 BIT_TICKS override 4, GAP_BITS=1 -> frame period 36 clocks; check counter wrap and single-cycle frame_done across 5 back-to-back frames.

Source files
------------

// File: rtl/ctrl_link_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_link_pkg
// Shared definitions for the controller serial link, used by the transmitter
// (ctrl_link_tx) and its matching receiver so both agree on framing.
//   - link_state_e    : FSM state encoding
//   - FRAME_DATA_BITS : button bits carried per frame
//   - FRAME_BITS      : total bit times per frame (start + data + parity + stop)
//   - BTN_*           : bit positions inside the btn vector
//   - frame_parity()  : even-parity bit over the button field
// ----------------------------------------------------------------------------
package ctrl_link_pkg;

  localparam int FRAME_DATA_BITS = 5;
  localparam int FRAME_BITS      = 8;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } link_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic frame_parity(input logic [FRAME_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
// Modulo-BIT_TICKS counter producing the bit-boundary strobe.
//   clk     : system clock
//   reset   : asynchronous active-high reset (counter -> 0)
//   restart : synchronous clear; holds the counter at 0 while asserted
//   tick    : high on the last clock of every bit time
// ----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int BIT_TICKS = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ctrl_link_tx.sv
// ----------------------------------------------------------------------------
// ctrl_link_tx
// Serial transmitter that repeatedly sends the live button vector to a partner
// board. Frame: start(0), btn[0..4] LSB first, even parity, stop(1), followed
// by GAP_BITS idle-high bit times.
//   clk        : system clock
//   reset      : asynchronous active-high reset (aborts any frame in flight)
//   enable     : 1 = send frames back to back; 0 = finish frame, then idle
//   btn        : {attack, right, left, down, up}, sampled at each frame start
//   tx_line    : registered serial output, idles high
//   busy       : high from the first clock of start to the last clock of stop
//   frame_done : one-clock pulse on the last clock of each stop bit
// ----------------------------------------------------------------------------
module ctrl_link_tx
  import ctrl_link_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int BIT_TICKS = CLK_HZ / BAUD,
  parameter int GAP_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [FRAME_DATA_BITS-1:0] btn,
  output logic                       tx_line,
  output logic                       busy,
  output logic                       frame_done
);

  localparam logic [2:0] DATA_LAST = 3'(FRAME_DATA_BITS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_BITS - 1);

  link_state_e                state_q, state_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [3:0]                 gap_cnt_q, gap_cnt_d;
  logic [FRAME_DATA_BITS-1:0] shadow_q, shadow_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic [2:0]                 next_idx;
  logic                       bit_tick;

  // The bit counter is held at 0 while idle, so the first start bit after
  // leaving IDLE is a full BIT_TICKS wide; elsewhere it free-runs and wraps
  // exactly on each bit boundary.
  baud_tick_gen #(
    .BIT_TICKS(BIT_TICKS)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(state_q == ST_IDLE),
    .tick   (bit_tick)
  );

  assign next_idx = bit_idx_q + 3'd1;

  // tx_line is updated on the same edge as the state change, so the line
  // value always belongs to the state it is registered alongside.
  always_comb begin
    // NOTE: every next-state signal gets its hold value first; without these
    // defaults the incomplete branches below would infer latches.
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    shadow_d  = shadow_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (enable) begin
          state_d  = ST_START;
          shadow_d = btn;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shadow_q[BTN_UP];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == DATA_LAST) begin
            state_d   = ST_PARITY;
            bit_idx_d = '0;
            tx_d      = frame_parity(shadow_q);
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shadow_q[next_idx];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          state_d   = ST_GAP;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (bit_tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (enable) begin
              // Next frame is latched here, so btn changes seen during the
              // previous frame only show up from this frame on.
              state_d  = ST_START;
              shadow_d = btn;
              tx_d     = 1'b0;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      // NOTE: the shadow register is control-path state observed on the line,
      // so it is reset along with the FSM rather than left uninitialised.
      shadow_q  <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      shadow_q  <= shadow_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_line = tx_q;
  assign busy    = busy_q;

  // Decoded purely from registers (state and bit counter), so there is no
  // path from btn or enable; it is high only on the final clock of STOP.
  assign frame_done = (state_q == ST_STOP) && bit_tick;

endmodule

// File: tb/tb_ctrl_link_tx.sv
// ----------------------------------------------------------------------------
// tb_ctrl_link_tx
// Two transmitters share one clock: dut_a with default timing (868 clocks per
// bit, 4 gap bits) and dut_b with 4 clocks per bit and 1 gap bit. A frame-level
// model per DUT predicts tx_line/busy/frame_done every clock from the position
// inside the current frame period; literal expectations pin specific frames.
// ----------------------------------------------------------------------------
module tb_ctrl_link_tx;

  localparam int BT_A  = 868;
  localparam int GAP_A = 4;
  localparam int PER_A = (8 + GAP_A) * BT_A;
  localparam int BT_B  = 4;
  localparam int GAP_B = 1;
  localparam int PER_B = (8 + GAP_B) * BT_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, en_a = 1'b0;
  logic [4:0] btn_a = 5'b00101;
  logic       tx_a, busy_a, fd_a;
  logic       rst_b = 1'b1, en_b = 1'b0;
  logic [4:0] btn_b = 5'b10011;
  logic       tx_b, busy_b, fd_b;

  ctrl_link_tx #(.GAP_BITS(GAP_A)) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .btn(btn_a),
    .tx_line(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  ctrl_link_tx #(.BIT_TICKS(BT_B), .GAP_BITS(GAP_B)) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .btn(btn_b),
    .tx_line(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame as transmitted, bit i = i-th bit time on the line.
  function automatic logic [7:0] build(input logic [4:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  // {tx_line, busy, frame_done} at clock 'pos' of a frame period.
  function automatic logic [2:0] expect_out(input bit act, input int pos,
                                            input logic [7:0] fr, input int bt);
    int b;
    if (!act) return 3'b100;
    b = pos / bt;
    if (b < 8) return {fr[b], 1'b1, (pos == 8 * bt - 1)};
    return 3'b100;
  endfunction

  // ---------------- frame-period models ----------------
  bit         ma_act = 1'b0, mb_act = 1'b0;
  int         ma_pos = 0, mb_pos = 0;
  logic [7:0] ma_fr = 8'hFF, mb_fr = 8'hFF;

  initial forever begin
    @(posedge clk or posedge rst_a);
    if (rst_a) begin
      ma_act = 1'b0; ma_pos = 0;
    end else if (ma_act) begin
      if (ma_pos == PER_A - 1) begin
        if (en_a) begin ma_pos = 0; ma_fr = build(btn_a); end
        else ma_act = 1'b0;
      end else ma_pos++;
    end else if (en_a) begin
      ma_act = 1'b1; ma_pos = 0; ma_fr = build(btn_a);
    end
  end

  initial forever begin
    @(posedge clk or posedge rst_b);
    if (rst_b) begin
      mb_act = 1'b0; mb_pos = 0;
    end else if (mb_act) begin
      if (mb_pos == PER_B - 1) begin
        if (en_b) begin mb_pos = 0; mb_fr = build(btn_b); end
        else mb_act = 1'b0;
      end else mb_pos++;
    end else if (en_b) begin
      mb_act = 1'b1; mb_pos = 0; mb_fr = build(btn_b);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("line_a", {tx_a, busy_a, fd_a}, expect_out(ma_act, ma_pos, ma_fr, BT_A));
    check("line_b", {tx_b, busy_b, fd_b}, expect_out(mb_act, mb_pos, mb_fr, BT_B));
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int         st_a[$], fd_qa[$], st_b[$], fd_qb[$];
  logic [7:0] fr_a[$], fr_b[$];
  logic [7:0] cur_a = '0, cur_b = '0;
  bit         pb_a = 1'b0, pb_b = 1'b0;
  int         off_a, off_b;

  initial forever begin
    @(negedge clk);
    if (busy_a && !pb_a) st_a.push_back(cyc);
    if (busy_a && st_a.size() > 0) begin
      off_a = cyc - st_a[$];
      if ((off_a % BT_A) == BT_A / 2 && off_a / BT_A < 8) cur_a[off_a / BT_A] = tx_a;
    end
    if (fd_a) begin fd_qa.push_back(cyc); fr_a.push_back(cur_a); end
    pb_a = busy_a;
  end

  initial forever begin
    @(negedge clk);
    if (busy_b && !pb_b) st_b.push_back(cyc);
    if (busy_b && st_b.size() > 0) begin
      off_b = cyc - st_b[$];
      if ((off_b % BT_B) == BT_B / 2 && off_b / BT_B < 8) cur_b[off_b / BT_B] = tx_b;
    end
    if (fd_b) begin fd_qb.push_back(cyc); fr_b.push_back(cur_b); end
    pb_b = busy_b;
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic int qsize(input int w);
    case (w)
      0:       return fr_a.size();
      1:       return st_a.size();
      2:       return fr_b.size();
      3:       return st_b.size();
      default: return fd_qb.size();
    endcase
  endfunction

  task automatic wait_q(input int w, input int n, input int budget, input string nm);
    int k = 0;
    while (qsize(w) < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check({"wait_", nm}, 32'(qsize(w) >= n), 1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(negedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  task automatic run_a();
    step(3);
    check("a_rst_tx", tx_a, 1);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_done", fd_a, 0);
    rst_a = 1'b0;
    step(5);
    check("a_idle_no_start", st_a.size(), 0);
    check("a_idle_tx", tx_a, 1);
    en_a = 1'b1;
    wait_q(0, 1, PER_A + 100, "a_f1");
    btn_a = 5'b10110;
    wait_q(0, 4, 3 * PER_A + 100, "a_f4");
    btn_a = 5'b00001;
    wait_q(1, 5, PER_A + 100, "a_s5");
    wait_cyc(st_a[4] + 3 * BT_A + BT_A / 2);   // inside DATA bit 2
    btn_a = 5'b11111;
    wait_q(1, 6, PER_A + 100, "a_s6");
    wait_cyc(st_a[5] + 6 * BT_A + BT_A / 2);   // inside PARITY
    en_a = 1'b0;
    wait_q(0, 6, PER_A, "a_f6");
    step(GAP_A * BT_A + 2000);
    check("a_no_restart", st_a.size(), 6);
    check("a_done_count", fd_qa.size(), 6);
    check("a_final_tx", tx_a, 1);
    check("a_final_busy", busy_a, 0);
    check("a_f1_bits", fr_a[0], 8'h8A);
    check("a_f1_done_ofs", fd_qa[0] - st_a[0], 6943);
    for (int i = 1; i <= 3; i++) check($sformatf("a_f%0d_bits", i + 1), fr_a[i], 8'hEC);
    for (int i = 0; i < 3; i++) check($sformatf("a_period%0d", i), st_a[i + 1] - st_a[i], 10416);
    check("a_f5_bits", fr_a[4], 8'hC2);
    check("a_f6_bits", fr_a[5], 8'hFE);
  endtask

  task automatic run_b();
    int rel;
    int nf;
    step(3);
    check("b_rst_tx", tx_b, 1);
    check("b_rst_busy", busy_b, 0);
    rst_b = 1'b0;
    step(2);
    en_b = 1'b1;
    wait_q(4, 5, 6 * PER_B, "b_fd5");
    check("b_f1_bits", fr_b[0], 8'hE6);
    check("b_f1_done_ofs", fd_qb[0] - st_b[0], 31);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_done_gap%0d", i), fd_qb[i + 1] - fd_qb[i], 36);
      check($sformatf("b_period%0d", i), st_b[i + 1] - st_b[i], 36);
    end
    wait_q(3, 7, 3 * PER_B, "b_s7");
    wait_cyc(st_b[6] + 4 * BT_B + 1);          // inside DATA bit 3 (btn[3]=0)
    check("b_pre_rst_tx", tx_b, 0);
    nf = fr_b.size();
    rst_b = 1'b1;
    #1;
    check("b_rst_async_tx", tx_b, 1);
    check("b_rst_async_busy", busy_b, 0);
    step(3);
    check("b_rst_hold_tx", tx_b, 1);
    rst_b = 1'b0;
    rel = cyc;
    wait_q(2, nf + 1, PER_B + 10, "b_after_rst");
    check("b_aborted_no_done", fr_b.size(), nf + 1);
    check("b_restart_latency", st_b[$] - rel, 1);
    check("b_restart_bits", fr_b[$], 8'hE6);
    en_b = 1'b0;
    step(PER_B + 10);
    check("b_final_busy", busy_b, 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
